// File: rtl/npc_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, canonical NOP and FSM states.
package npc_pkg;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   // addi x0, x0, 0 -- substituted for any word that came back with an access fault
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_OUT
   } ifu_state_e;

endpackage

// File: rtl/ifu_pc_gen.sv
// Program counter register and next-PC selection (reset / redirect / sequential / hold).
module ifu_pc_gen
   import npc_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = npc_pkg::RESET_PC
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            advance_i,
   output logic [XLEN-1:0] pc_o
);

   // Fetches are always word aligned; the low two bits never reach the bus.
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_q;

   // Next PC: a redirect wins over the sequential step; otherwise hold.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid_i) begin
         pc_d = redirect_pc_i & ALIGN_MASK;
      end else if (advance_i) begin
         // Wraps naturally modulo 2^XLEN.
         pc_d = pc_q + XLEN'(4);
      end
   end

   // PC register with asynchronous reset to the boot address.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC & ALIGN_MASK;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: issues one word read at a time, buffers the returned instruction
// for decode, and discards responses that belong to a fetch overtaken by a redirect.
module ifu_fetch
   import npc_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = npc_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   // instruction memory request
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   // instruction memory response
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            imem_rsp_err,
   // control-flow change from execute
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   // decode interface
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_err
);

   ifu_state_e      state_q;
   logic            drop_q;
   logic            inst_valid_q;
   logic [XLEN-1:0] inst_q;
   logic [XLEN-1:0] inst_pc_q;
   logic            inst_err_q;

   logic [XLEN-1:0] pc;
   logic            advance;

   // The PC only steps once decode has taken the buffered instruction.
   assign advance = (state_q == S_OUT) && inst_ready;

   ifu_pc_gen #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk_i            (clk),
      .rst_i            (rst),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .advance_i        (advance),
      .pc_o             (pc)
   );

   // Fetch FSM, stale-response drop flag and decode output buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_BOOT;
         drop_q       <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= XLEN'(INST_NOP);
         inst_pc_q    <= RESET_PC;
         inst_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_BOOT: begin
               state_q <= S_REQ;
            end

            S_REQ: begin
               if (imem_req_ready) begin
                  // A redirect in the acceptance cycle orphans the request just issued.
                  drop_q  <= redirect_valid;
                  state_q <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (drop_q || redirect_valid) begin
                     drop_q  <= 1'b0;
                     state_q <= S_REQ;
                  end else begin
                     inst_q       <= imem_rsp_err ? XLEN'(INST_NOP) : imem_rsp_data;
                     inst_err_q   <= imem_rsp_err;
                     inst_pc_q    <= pc;
                     inst_valid_q <= 1'b1;
                     state_q      <= S_OUT;
                  end
               end else if (redirect_valid) begin
                  drop_q <= 1'b1;
               end
            end

            S_OUT: begin
               // Either consumed or squashed; the PC update is handled in ifu_pc_gen.
               if (redirect_valid || inst_ready) begin
                  inst_valid_q <= 1'b0;
                  state_q      <= S_REQ;
               end
            end

            default: begin
               state_q <= S_BOOT;
            end
         endcase
      end
   end

   // Request side is decoded straight from the state register, so it is glitch free.
   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = pc;

   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_err   = inst_err_q;

   // An unaccepted request keeps its address unless execute redirects.
   a_req_stable : assert property (@(posedge clk) disable iff (rst)
      (imem_req_valid && !imem_req_ready && !redirect_valid)
      |=> (imem_req_valid && $stable(imem_req_addr)));

   // A stalled instruction is held unchanged for decode.
   a_inst_stable : assert property (@(posedge clk) disable iff (rst)
      (inst_valid && !inst_ready && !redirect_valid)
      |=> (inst_valid && $stable(inst) && $stable(inst_pc) && $stable(inst_err)));

   // Only one fetch in flight: never requesting while an instruction is buffered.
   a_single_outstanding : assert property (@(posedge clk) disable iff (rst)
      !(imem_req_valid && inst_valid));

endmodule
